// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Field slices follow the MIPS-style opcode/rs/rt/imm16 layout.
package fetch_pkg;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fetch_state_e;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0180;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm16;
  } instr_fields_t;

  function automatic instr_fields_t decode_fields(input logic [31:0] w);
    instr_fields_t f;
    f.opcode = w[OPCODE_MSB:OPCODE_LSB];
    f.rs     = w[RS_MSB:RS_LSB];
    f.rt     = w[RT_MSB:RT_LSB];
    f.imm16  = w[IMM_MSB:IMM_LSB];
    return f;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bundle: instruction-memory read port, IR handshake to control,
// and redirect/exception sideband. master = fetch unit, slave = environment.
interface fetch_if #(
  parameter int XLEN = 32
);
  import fetch_pkg::*;

  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic [31:0]     mem_rdata;
  logic            mem_rvalid;

  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     ir;
  instr_fields_t   fields;
  logic [XLEN-1:0] pc;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            exc_req;
  logic            exc_taken;
  logic [XLEN-1:0] epc;

  modport master (
    output mem_req, mem_addr, instr_valid, ir, fields, pc, exc_taken, epc,
    input  mem_rdata, mem_rvalid, instr_ready, redirect_valid, redirect_pc, exc_req
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, ir, fields, pc, exc_taken, epc,
    output mem_rdata, mem_rvalid, instr_ready, redirect_valid, redirect_pc, exc_req
  );

endinterface

// File: rtl/fetch_next_pc.sv
// Next-PC selection: exception vector > redirect target > sequential > hold.
// A redirect to a non-word-aligned target is turned into an exception entry.
module fetch_next_pc #(
  parameter int              XLEN       = 32,
  parameter int              PC_STEP    = 4,
  parameter logic [XLEN-1:0] EXC_VECTOR = '0
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            exc_req,
  input  logic            redirect_valid,
  input  logic            transfer,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] epc_next,
  output logic            exc_entry
);

  logic misaligned;

  always_comb begin
    misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
    exc_entry  = exc_req || misaligned;
    epc_next   = exc_req ? pc : redirect_pc;
    next_pc    = pc;
    if (exc_entry)           next_pc = EXC_VECTOR;
    else if (redirect_valid) next_pc = redirect_pc;
    else if (transfer)       next_pc = pc + XLEN'(PC_STEP);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC/IR/EPC, keeps one read outstanding to
// variable-latency memory, and presents IR to control over valid/ready.
module fetch_unit import fetch_pkg::*; #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter logic [XLEN-1:0] EXC_VECTOR = XLEN'(DEF_EXC_VECTOR),
  parameter int              PC_STEP    = 4
) (
  input  logic     clock,
  input  logic     reset,
  fetch_if.master  bus
);

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt, npc;
  logic [XLEN-1:0] epc, epc_nxt, epc_new;
  logic [31:0]     ir, ir_nxt;
  logic            exc_taken;
  logic            in_hold, transfer, exc_hon, exc_entry, flush;

  assign in_hold  = (state == HOLD);
  assign transfer = in_hold && bus.instr_ready;
  assign exc_hon  = in_hold && bus.exc_req;
  assign flush    = exc_entry || bus.redirect_valid;

  fetch_next_pc #(
    .XLEN       (XLEN),
    .PC_STEP    (PC_STEP),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_next_pc (
    .pc             (pc),
    .redirect_pc    (bus.redirect_pc),
    .exc_req        (exc_hon),
    .redirect_valid (bus.redirect_valid),
    .transfer       (transfer),
    .next_pc        (npc),
    .epc_next       (epc_new),
    .exc_entry      (exc_entry)
  );

  always_comb begin
    state_nxt = state;
    ir_nxt    = ir;
    pc_nxt    = npc;
    epc_nxt   = exc_entry ? epc_new : epc;
    case (state)
      ISSUE: state_nxt = flush ? DRAIN : WAIT;
      WAIT: begin
        // A redirect racing the returning data drops that data on the floor.
        if (flush)                state_nxt = bus.mem_rvalid ? ISSUE : DRAIN;
        else if (bus.mem_rvalid) begin
          ir_nxt    = bus.mem_rdata;
          state_nxt = HOLD;
        end
      end
      HOLD:  if (flush || transfer) state_nxt = ISSUE;
      // Redirects here only move pc; the stale read must still retire.
      DRAIN: if (bus.mem_rvalid) state_nxt = ISSUE;
      default: state_nxt = ISSUE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ISSUE;
      pc        <= RESET_PC;
      ir        <= '0;
      epc       <= '0;
      exc_taken <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      ir        <= ir_nxt;
      epc       <= epc_nxt;
      exc_taken <= exc_entry;
    end
  end

  assign bus.mem_req     = (state == ISSUE) && !reset;
  assign bus.mem_addr    = pc;
  assign bus.instr_valid = in_hold;
  assign bus.ir          = ir;
  assign bus.fields      = decode_fields(ir);
  assign bus.pc          = pc;
  assign bus.exc_taken   = exc_taken;
  assign bus.epc         = epc;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a 32-bit instance for fetch/redirect/exception
// flows and a 16-bit instance for PC wrap and mid-read reset.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst32 = 1'b1;
  logic rst16 = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   lat32 = 1;
  int   lat16 = 1;

  logic [31:0] q_req[$];
  logic [63:0] q_xfer[$];
  logic [31:0] q_exc[$];
  logic [15:0] q16_req[$];
  logic [47:0] q16_xfer[$];

  fetch_if #(.XLEN(32)) f32();
  fetch_if #(.XLEN(16)) f16();

  fetch_unit #(.XLEN(32)) dut32 (.clock(clk), .reset(rst32), .bus(f32.master));
  fetch_unit #(.XLEN(16), .RESET_PC(16'hFFFC)) dut16 (.clock(clk), .reset(rst16), .bus(f16.master));

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h2002_0005 : (32'h8C00_0000 ^ a);
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory models: a request seen in cycle c answers in cycle c+lat.
  initial begin : resp32
    int cnt;
    logic [31:0] a;
    cnt = 0; a = '0;
    f32.mem_rvalid = 1'b0; f32.mem_rdata = '0;
    forever begin
      @(negedge clk);
      f32.mem_rvalid = 1'b0;
      if (rst32) cnt = 0;
      else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            f32.mem_rvalid = 1'b1;
            f32.mem_rdata  = mem_word(a);
            chk("rvalid_proto32", 64'(f32.mem_req || f32.instr_valid), 0);
          end
        end
        if (f32.mem_req) begin cnt = lat32; a = f32.mem_addr; end
      end
    end
  end

  initial begin : resp16
    int cnt;
    logic [31:0] a;
    cnt = 0; a = '0;
    f16.mem_rvalid = 1'b0; f16.mem_rdata = '0;
    forever begin
      @(negedge clk);
      f16.mem_rvalid = 1'b0;
      if (rst16) cnt = 0;
      else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            f16.mem_rvalid = 1'b1;
            f16.mem_rdata  = mem_word(a);
            chk("rvalid_proto16", 64'(f16.mem_req || f16.instr_valid), 0);
          end
        end
        if (f16.mem_req) begin cnt = lat16; a = 32'(f16.mem_addr); end
      end
    end
  end

  // Monitors pop expectations whenever the DUT shows a request, transfer or exception.
  initial forever begin
    @(negedge clk);
    if (!rst32) begin
      if (f32.mem_req) begin
        chk("req_expected32", 64'(q_req.size() > 0), 1);
        if (q_req.size() > 0) chk("mem_addr32", f32.mem_addr, q_req.pop_front());
      end
      if (f32.instr_valid && f32.instr_ready && !f32.redirect_valid && !f32.exc_req) begin
        chk("xfer_expected32", 64'(q_xfer.size() > 0), 1);
        if (q_xfer.size() > 0) chk("pc_ir32", {f32.pc, f32.ir}, q_xfer.pop_front());
      end
      if (f32.exc_taken) begin
        chk("exc_expected32", 64'(q_exc.size() > 0), 1);
        if (q_exc.size() > 0) chk("epc32", f32.epc, q_exc.pop_front());
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst16) begin
      if (f16.mem_req) begin
        chk("req_expected16", 64'(q16_req.size() > 0), 1);
        if (q16_req.size() > 0) chk("mem_addr16", f16.mem_addr, q16_req.pop_front());
      end
      if (f16.instr_valid && f16.instr_ready) begin
        chk("xfer_expected16", 64'(q16_xfer.size() > 0), 1);
        if (q16_xfer.size() > 0) chk("pc_ir16", {f16.pc, f16.ir}, q16_xfer.pop_front());
      end
      chk("exc_quiet16", 64'(f16.exc_taken), 0);
    end
  end

  task automatic wait_hold32(output int n);
    n = 0;
    while (!f32.instr_valid && n < 30) begin tick(); n++; end
    chk("hold32_reached", 64'(f32.instr_valid), 1);
  endtask

  task automatic wait_hold16(output int n);
    n = 0;
    while (!f16.instr_valid && n < 30) begin tick(); n++; end
    chk("hold16_reached", 64'(f16.instr_valid), 1);
  endtask

  task automatic xfer32();
    f32.instr_ready = 1'b1; tick(); f32.instr_ready = 1'b0;
  endtask

  task automatic xfer16();
    f16.instr_ready = 1'b1; tick(); f16.instr_ready = 1'b0;
  endtask

  task automatic redirect32(input logic [31:0] target);
    f32.redirect_valid = 1'b1; f32.redirect_pc = target;
    tick();
    f32.redirect_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int n;
    f32.instr_ready = 1'b0; f32.redirect_valid = 1'b0; f32.redirect_pc = '0; f32.exc_req = 1'b0;
    f16.instr_ready = 1'b0; f16.redirect_valid = 1'b0; f16.redirect_pc = '0; f16.exc_req = 1'b0;
    repeat (3) tick();

    chk("rst_pc", f32.pc, 0);
    chk("rst_ir", f32.ir, 0);
    chk("rst_epc", f32.epc, 0);
    chk("rst_valid", 64'(f32.instr_valid), 0);
    chk("rst_exc", 64'(f32.exc_taken), 0);
    chk("rst_req", 64'(f32.mem_req), 0);

    // Two in-order fetches at minimum latency.
    q_req.push_back(32'h0);  q_xfer.push_back({32'h0, 32'h2002_0005});
    q_req.push_back(32'h4);  q_xfer.push_back({32'h4, mem_word(32'h4)});
    q_req.push_back(32'h8);
    rst32 = 1'b0;
    wait_hold32(n);
    chk("lat_min_first", n, 2);
    chk("opcode", f32.fields.opcode, 6'h08);
    chk("rs", f32.fields.rs, 5'd0);
    chk("rt", f32.fields.rt, 5'd2);
    chk("imm16", f32.fields.imm16, 16'h0005);
    xfer32();
    wait_hold32(n);
    chk("lat_min_second", n, 2);
    lat32 = 3;
    xfer32();

    // Latency 3, then IR held while control stalls.
    wait_hold32(n);
    chk("lat3", n, 4);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 64'(f32.instr_valid), 1);
      chk("stall_pc", f32.pc, 32'h8);
      chk("stall_ir", f32.ir, mem_word(32'h8));
      chk("stall_noreq", 64'(f32.mem_req), 0);
      tick();
    end
    q_xfer.push_back({32'h8, mem_word(32'h8)});
    q_req.push_back(32'hC);
    xfer32();

    // Redirect while the read is in flight; stale data must not reach IR.
    q_req.push_back(32'h40);
    tick();
    redirect32(32'h40);
    chk("drain_pc", f32.pc, 32'h40);
    chk("drain_valid", 64'(f32.instr_valid), 0);
    wait_hold32(n);
    chk("redir_pc", f32.pc, 32'h40);
    chk("redir_ir", f32.ir, mem_word(32'h40));

    // Redirect from HOLD, then exception entry on pc 0x10.
    lat32 = 1;
    q_req.push_back(32'h10);
    redirect32(32'h10);
    wait_hold32(n);
    chk("hold_redir_pc", f32.pc, 32'h10);
    q_exc.push_back(32'h10);
    q_req.push_back(32'h180);
    f32.exc_req = 1'b1;
    tick();
    chk("exc_pc", f32.pc, 32'h180);
    chk("exc_epc", f32.epc, 32'h10);
    chk("exc_pulse", 64'(f32.exc_taken), 1);
    chk("exc_valid", 64'(f32.instr_valid), 0);
    tick();
    f32.exc_req = 1'b0;
    chk("exc_pulse_end", 64'(f32.exc_taken), 0);
    wait_hold32(n);
    chk("exc_epc_kept", f32.epc, 32'h10);
    q_xfer.push_back({32'h180, mem_word(32'h180)});
    q_req.push_back(32'h184);
    xfer32();
    wait_hold32(n);

    // Misaligned redirect becomes an exception.
    q_exc.push_back(32'h42);
    q_req.push_back(32'h180);
    redirect32(32'h42);
    chk("mis_epc", f32.epc, 32'h42);
    chk("mis_pc", f32.pc, 32'h180);
    chk("mis_pulse", 64'(f32.exc_taken), 1);
    wait_hold32(n);

    // Redirect and transfer together: redirect target wins, no increment.
    q_req.push_back(32'h20);
    f32.instr_ready = 1'b1;
    redirect32(32'h20);
    f32.instr_ready = 1'b0;
    chk("rx_pc", f32.pc, 32'h20);
    wait_hold32(n);
    chk("rx_ir", f32.ir, mem_word(32'h20));

    // 16-bit PC wraps, then reset lands mid-read.
    q16_req.push_back(16'hFFFC); q16_xfer.push_back({16'hFFFC, mem_word(32'h0000_FFFC)});
    q16_req.push_back(16'h0000); q16_xfer.push_back({16'h0000, 32'h2002_0005});
    q16_req.push_back(16'h0004);
    rst16 = 1'b0;
    wait_hold16(n);
    chk("w16_pc0", f16.pc, 16'hFFFC);
    chk("w16_fields", 64'(f16.fields), mem_word(32'h0000_FFFC));
    xfer16();
    wait_hold16(n);
    chk("w16_wrap", f16.pc, 16'h0000);
    lat16 = 3;
    xfer16();
    tick();
    rst16 = 1'b1;
    tick();
    chk("r16_pc", f16.pc, 16'hFFFC);
    chk("r16_valid", 64'(f16.instr_valid), 0);
    chk("r16_req", 64'(f16.mem_req), 0);
    q16_req.push_back(16'hFFFC);
    tick();
    rst16 = 1'b0;
    wait_hold16(n);
    chk("r16_refetch_pc", f16.pc, 16'hFFFC);
    chk("r16_refetch_ir", f16.ir, mem_word(32'h0000_FFFC));

    repeat (3) tick();
    chk("q_req_empty", q_req.size(), 0);
    chk("q_xfer_empty", q_xfer.size(), 0);
    chk("q_exc_empty", q_exc.size(), 0);
    chk("q16_req_empty", q16_req.size(), 0);
    chk("q16_xfer_empty", q16_xfer.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
